// File: rtl/controller_responder_if.sv
// Console-side link bundle for the controller responder: the button and pin inputs plus the pad outputs.
// The master modport is the console/board side and the slave modport is the pad side.
interface controller_responder_if;
  logic [7:0] buttons_B;
  logic       controller_latch;
  logic       controller_clk;
  logic       controller_data_B;
  logic       busy;
  logic       poll_done;
  logic       overrun;

  modport master (
    output buttons_B, controller_latch, controller_clk,
    input  controller_data_B, busy, poll_done, overrun
  );
  modport slave (
    input  buttons_B, controller_latch, controller_clk,
    output controller_data_B, busy, poll_done, overrun
  );
endinterface

// File: rtl/controller_responder.sv
// 4021-style serial pad responder: synchronizes the latch and clk pins and shifts 8 active-low buttons MSB-first.
// Optional button debounce is enabled with the macro CONTROLLER_RESPONDER__DEBOUNCE_EN.
`ifdef CONTROLLER_RESPONDER__DEBOUNCE_EN
module controller_responder_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_1,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;

  // The counter tracks consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b1;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule
`endif

module controller_responder #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic FILL_B          = 1'b1
) (
  input  logic                   clk_1,
  input  logic                   rst,
  controller_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0]      latch_sync, clk_sync;
  logic [SYNC_STAGES-1:0][7:0] btn_sync;
  logic                        latch_d, clk_d;
  logic                        latch_s, clk_s, latch_fall, clk_rise;
  logic [7:0]                  btn_s, btn_cap;

  state_t     state;
  logic [7:0] shift_reg;
  logic [3:0] bit_cnt;
  logic       data_b, busy, poll_done, overrun;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      latch_sync <= '0;
      clk_sync   <= '0;
      btn_sync   <= {SYNC_STAGES{8'hFF}};
      latch_d    <= 1'b0;
      clk_d      <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], bus.controller_latch};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], bus.controller_clk};
      btn_sync   <= {btn_sync[SYNC_STAGES-2:0], bus.buttons_B};
      latch_d    <= latch_s;
      clk_d      <= clk_s;
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign btn_s      = btn_sync[SYNC_STAGES-1];
  assign latch_fall = latch_d & ~latch_s;
  assign clk_rise   = clk_s & ~clk_d;

`ifdef CONTROLLER_RESPONDER__DEBOUNCE_EN
  for (genvar i = 0; i < 8; i++) begin : g_db
    controller_responder_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_1 (clk_1),
      .rst   (rst),
      .din   (btn_s[i]),
      .dout  (btn_cap[i])
    );
  end
`else
  assign btn_cap = btn_s;
`endif

  // A high latch level outranks a clk edge in the same cycle, so an abort drops that edge.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= 8'hFF;
      bit_cnt   <= '0;
      data_b    <= 1'b1;
      busy      <= 1'b0;
      poll_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      poll_done <= 1'b0;
      unique case (state)
        IDLE: begin
          data_b <= shift_reg[7];
          if (latch_s) state <= LOAD;
        end
        LOAD: begin
          shift_reg <= btn_cap;
          data_b    <= btn_cap[7];
          if (latch_fall) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (latch_s) begin
            overrun <= 1'b1;
            busy    <= 1'b0;
            state   <= LOAD;
          end else if (clk_rise) begin
            shift_reg <= {shift_reg[6:0], FILL_B};
            data_b    <= shift_reg[6];
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              poll_done <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          data_b <= FILL_B;
          if (latch_s) state <= LOAD;
          else if (clk_rise) shift_reg <= {shift_reg[6:0], FILL_B};
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.controller_data_B = data_b;
  assign bus.busy              = busy;
  assign bus.poll_done         = poll_done;
  assign bus.overrun           = overrun;
endmodule

// File: tb/tb_controller_responder.sv
// Randomized scoreboard bench for controller_responder: a poll model queues the expected serial bits,
// and a monitor compares them against data_B at every console clk rise.
module tb_controller_responder;
  localparam int P = 6;

  logic clk_1 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_1 = ~clk_1;

  controller_responder_if bus();
  controller_responder dut (.clk_1(clk_1), .rst(rst), .bus(bus));

  int checks = 0, failures = 0;
  int done_cnt = 0, exp_done = 0;
  bit exp_q[$];
  bit exp_ov = 1'b0;
  bit mid_poll = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk_1);
  endtask

  // The console samples data just before it raises clk, which is what this monitor mirrors.
  always @(posedge bus.controller_clk) begin
    if (exp_q.size() > 0) begin
      bit e;
      e = exp_q.pop_front();
      chk("serial_bit", {31'd0, bus.controller_data_B}, {31'd0, e});
    end
  end

  always @(negedge clk_1) if (bus.poll_done === 1'b1) done_cnt++;

  // The reference model: bits leave MSB first, and a latch rise while a poll is unfinished is an overrun.
  task automatic poll(logic [7:0] b, int nclk, bit same_edge);
    bus.buttons_B = b;
    cyc(P);
    bus.controller_latch = 1'b1;
    if (same_edge) bus.controller_clk = 1'b1;
    if (mid_poll) exp_ov = 1'b1;
    cyc(P);
    bus.controller_clk = 1'b0;
    cyc(P);
    chk("overrun_after_latch", {31'd0, bus.overrun}, {31'd0, exp_ov});
    chk("busy_while_latched", {31'd0, bus.busy}, 32'd0);
    bus.controller_latch = 1'b0;
    cyc(P);
    chk("busy_after_fall", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < nclk; i++) begin
      exp_q.push_back(b[7-i]);
      bus.controller_clk = 1'b1;
      cyc(P);
      bus.controller_clk = 1'b0;
      cyc(P);
    end
    mid_poll = (nclk < 8);
    if (nclk == 8) begin
      exp_done++;
      chk("data_after_poll", {31'd0, bus.controller_data_B}, 32'd1);
      chk("busy_after_poll", {31'd0, bus.busy}, 32'd0);
      chk("poll_done_count", done_cnt, exp_done);
      chk("queue_drained", exp_q.size(), 32'd0);
    end
    chk("overrun_end", {31'd0, bus.overrun}, {31'd0, exp_ov});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.buttons_B = 8'h00;
    bus.controller_latch = 1'b0;
    bus.controller_clk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("rst_data", {31'd0, bus.controller_data_B}, 32'd1);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    end
    rst = 1'b0;
    cyc(P);

    poll(8'h01, 8, 1'b0);
    poll(8'h7F, 8, 1'b0);
    // An abort after 3 bits, followed by a full poll that must return fresh data.
    poll(8'hC3, 3, 1'b0);
    poll(8'hA5, 8, 1'b0);
    // A latch rise coinciding with a clk rise mid-shift.
    poll(8'h5A, 2, 1'b0);
    poll(8'h3C, 8, 1'b1);

    // An asynchronous reset mid-shift returns everything to the reset values.
    poll(8'h0F, 3, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    cyc(2);
    chk("midrst_data", {31'd0, bus.controller_data_B}, 32'd1);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_overrun", {31'd0, bus.overrun}, 32'd0);
    rst = 1'b0;
    exp_ov = 1'b0;
    mid_poll = 1'b0;
    cyc(P);
    poll(8'h96, 8, 1'b0);

    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      int n;
      b = 8'($urandom);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
      poll(b, n, 1'($urandom_range(0, 1)));
    end
    poll(8'($urandom), 8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
